// File: rtl/tile_pkg.sv
// tile_pkg: tile grid sizing helpers shared by tile_sequencer and blk_buffer.
package tile_pkg;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
  function automatic int idx_width(input int range_n);
    return range_n > 1 ? $clog2(range_n) : 1;
  endfunction
  function automatic int blks(input int h, input int v, input int tw, input int th);
    return ceil_div(h, tw) * ceil_div(v, th);
  endfunction
endpackage

// File: rtl/tile_axis_counter.sv
// tile_axis_counter: sub-tile position counter that advances a base by STEP every SPAN steps, saturating after LIMIT tiles.
module tile_axis_counter import tile_pkg::*; #(
  parameter int SPAN  = 16,
  parameter int LIMIT = 120,
  parameter int STEP  = 1,
  parameter int BW    = 7
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          i_clr,
  input  logic          i_step,
  output logic [BW-1:0] o_base,
  output logic          o_sat
);
  localparam int SW = idx_width(SPAN);
  logic [SW-1:0] r_sub;
  logic [BW-1:0] r_base;
  logic          r_over;
  logic [SW-1:0] w_sub;
  logic [BW-1:0] w_base;
  logic          w_over, w_wrap, w_last;
  // clr applies to the current step, so the cleared position is used this cycle
  assign w_sub  = i_clr ? '0 : r_sub;
  assign w_base = i_clr ? '0 : r_base;
  assign w_over = i_clr ? 1'b0 : r_over;
  assign w_wrap = i_step & (w_sub == SW'(SPAN - 1));
  assign w_last = w_base == BW'((LIMIT - 1) * STEP);
  assign o_base = w_base;
  assign o_sat  = w_over;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sub  <= '0;
      r_base <= '0;
      r_over <= 1'b0;
    end else begin
      r_sub  <= i_step ? (w_wrap ? '0 : w_sub + SW'(1)) : w_sub;
      r_base <= (w_wrap & ~w_last) ? w_base + BW'(STEP) : w_base;
      r_over <= w_over | (w_wrap & w_last);
    end
  end
endmodule

// File: rtl/tile_sequencer.sv
// tile_sequencer: maps video timing to per-pixel tile index and frame strobes, one cycle of latency.
module tile_sequencer import tile_pkg::*; #(
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int TILE_W   = 16,
  parameter int TILE_H   = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        vs_i,
  input  logic        hs_i,
  input  logic        de_i,
  output logic [31:0] tile_o,
  output logic        de_o,
  output logic        hs_o,
  output logic        vs_o,
  output logic        vs_r_o,
  output logic        freeze_o,
  output logic        locked_o,
  output logic        overflow_o
);
  localparam int COLS = ceil_div(H_ACTIVE, TILE_W);
  localparam int ROWS = ceil_div(V_ACTIVE, TILE_H);
  localparam int XW   = idx_width(COLS);
  localparam int TW   = idx_width(blks(H_ACTIVE, V_ACTIVE, TILE_W, TILE_H));
  logic          r_vs, r_vs_r, r_de_q, r_de, r_hs, r_freeze, r_locked, r_ovf;
  logic [31:0]   r_tile;
  logic          w_vs_rise, w_de_rise, w_de_fall, w_open, w_xsat, w_ysat;
  logic [XW-1:0] w_col;
  logic [TW-1:0] w_row_base;
  assign w_vs_rise = vs_i & ~r_vs;
  assign w_de_rise = de_i & ~r_de_q;
  assign w_de_fall = ~de_i & r_de_q;
  // a pixel coinciding with the locking vs edge already belongs to a valid frame
  assign w_open    = r_locked | w_vs_rise;
  tile_axis_counter #(.SPAN(TILE_W), .LIMIT(COLS), .STEP(1), .BW(XW)) u_x (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_clr(w_de_rise), .i_step(de_i),
    .o_base(w_col), .o_sat(w_xsat)
  );
  tile_axis_counter #(.SPAN(TILE_H), .LIMIT(ROWS), .STEP(COLS), .BW(TW)) u_y (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_clr(w_vs_rise), .i_step(w_de_fall),
    .o_base(w_row_base), .o_sat(w_ysat)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      {r_vs, r_vs_r, r_de_q, r_de, r_hs, r_freeze, r_locked, r_ovf} <= '0;
      r_tile <= '0;
    end else begin
      r_vs     <= vs_i;
      r_vs_r   <= r_vs;
      r_freeze <= w_vs_rise;
      r_de_q   <= de_i;
      r_hs     <= hs_i;
      r_de     <= de_i & w_open;
      r_locked <= w_open;
      r_ovf    <= ~w_vs_rise & (r_ovf | (de_i & (w_xsat | w_ysat)));
      if (de_i & w_open) r_tile <= 32'(TW'(w_col) + w_row_base);
    end
  end
  assign tile_o     = r_tile;
  assign de_o       = r_de;
  assign hs_o       = r_hs;
  assign vs_o       = r_vs;
  assign vs_r_o     = r_vs_r;
  assign freeze_o   = r_freeze;
  assign locked_o   = r_locked;
  assign overflow_o = r_ovf;
endmodule

// File: tb/tb_tile_sequencer.sv
// tb_tile_sequencer: directed frames on an 8x4 grid of 4x2 tiles, scoreboarded per de_o pixel.
module tb_tile_sequencer;
  logic clk_i = 1'b0, rst_ni = 1'b0, vs_i = 1'b0, hs_i = 1'b0, de_i = 1'b0;
  logic [31:0] tile_o;
  logic de_o, hs_o, vs_o, vs_r_o, freeze_o, locked_o, overflow_o;
  typedef struct packed {logic [31:0] t; logic o;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0, n_frz = 0, f0 = 0;

  tile_sequencer #(.H_ACTIVE(8), .V_ACTIVE(4), .TILE_W(4), .TILE_H(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i),
    .tile_o(tile_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .vs_r_o(vs_r_o),
    .freeze_o(freeze_o), .locked_o(locked_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk_i) begin
    if (freeze_o) n_frz++;
    if (rst_ni && de_o) begin
      if (q.size() == 0) chk("unexpected_de_o", {31'd0, de_o}, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("tile_o", tile_o, e.t);
        chk("overflow_o", {31'd0, overflow_o}, {31'd0, e.o});
      end
    end
  end

  task automatic drive(input logic vs, input logic hs, input logic de);
    vs_i = vs; hs_i = hs; de_i = de;
    @(posedge clk_i); #1;
  endtask

  task automatic line(input int n, input logic [31:0] t0, input logic [31:0] t1,
                      input int ovf_from, input bit on, input bit vs_first);
    for (int i = 0; i < n; i++) begin
      if (on) q.push_back('{t: (i < 4) ? t0 : t1, o: (i >= ovf_from)});
      drive(vs_first && i == 0, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic vs_pulse();
    drive(1'b1, 1'b0, 1'b0);
    chk("freeze_on_rise", {31'd0, freeze_o}, 32'd1);
    chk("vs_r_o_on_rise", {31'd0, vs_r_o}, 32'd0);
    chk("locked_after_vs", {31'd0, locked_o}, 32'd1);
    chk("overflow_clr_vs", {31'd0, overflow_o}, 32'd0);
    drive(1'b1, 1'b0, 1'b0);
    chk("freeze_one_shot", {31'd0, freeze_o}, 32'd0);
    chk("vs_r_o_follow", {31'd0, vs_r_o}, 32'd1);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame4();
    line(8, 0, 1, 99, 1'b1, 1'b0);
    line(8, 0, 1, 99, 1'b1, 1'b0);
    line(8, 2, 3, 99, 1'b1, 1'b0);
    line(8, 2, 3, 99, 1'b1, 1'b0);
  endtask

  initial begin
    #3;
    chk("rst_tile", tile_o, 0);
    chk("rst_outs", {25'd0, de_o, hs_o, vs_o, vs_r_o, freeze_o, locked_o, overflow_o}, 0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    line(8, 0, 0, 99, 1'b0, 1'b0);
    line(8, 0, 0, 99, 1'b0, 1'b0);
    chk("unlocked", {31'd0, locked_o}, 0);
    drive(1'b0, 1'b1, 1'b0);
    chk("hs_o_high", {31'd0, hs_o}, 1);
    drive(1'b0, 1'b0, 1'b0);
    chk("hs_o_low", {31'd0, hs_o}, 0);
    f0 = n_frz;
    vs_pulse();
    frame4();
    chk("freeze_count", n_frz - f0, 1);
    vs_pulse();
    line(10, 0, 1, 8, 1'b1, 1'b0);
    chk("overflow_sticky", {31'd0, overflow_o}, 1);
    vs_pulse();
    frame4();
    line(8, 2, 3, 0, 1'b1, 1'b0);
    line(8, 2, 3, 0, 1'b1, 1'b0);
    vs_pulse();
    line(8, 0, 1, 99, 1'b1, 1'b0);
    line(10, 0, 1, 8, 1'b1, 1'b0);
    line(8, 0, 1, 99, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      q.push_back('{t: 32'd0, o: 1'b0});
      drive(1'b0, 1'b0, 1'b1);
    end
    @(negedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_tile", tile_o, 0);
    chk("async_rst_outs", {25'd0, de_o, hs_o, vs_o, vs_r_o, freeze_o, locked_o, overflow_o}, 0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    line(8, 0, 0, 99, 1'b0, 1'b0);
    chk("relock_wait", {31'd0, locked_o}, 0);
    f0 = n_frz;
    vs_pulse();
    frame4();
    chk("freeze_count2", n_frz - f0, 1);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    chk("sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
